cu_ext: RTL



---
 rtl/cu_ext.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cu_ext.sv
// Multi-cycle control unit for the accumulator datapath: 3/4-bit opcodes,
// memory wait states, single-shot input capture and illegal-opcode trap.
module cu_ext #(
  parameter int OPW         = 4,
  parameter bit HALT_RESUME = 1'b0
) (
  input  logic           Reset,
  input  logic           Clock,
  input  logic [OPW-1:0] IR,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic           Enter,
  input  logic           MemReady,
  output logic           IRload,
  output logic           PCload,
  output logic           JMPmux,
  output logic           Meminst,
  output logic           MemWr,
  output logic           Aload,
  output logic           Sub,
  output logic [1:0]     Asel,
  output logic           Outload,
  output logic           Halt,
  output logic           Err,
  output logic [4:0]     state
);

  typedef enum logic [4:0] {
    S_START  = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_LOAD   = 5'd8,
    S_STORE  = 5'd9,
    S_ADD    = 5'd10,
    S_SUB    = 5'd11,
    S_INPUT  = 5'd12,
    S_JZ     = 5'd13,
    S_JPOS   = 5'd14,
    S_HALT   = 5'd15,
    S_OUT    = 5'd16,
    S_JNZ    = 5'd17,
    S_JMP    = 5'd18,
    S_NOP    = 5'd19,
    S_TRAP   = 5'd20
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_op;

  // A 3-bit opcode zero-extends, so the 8-15 decode arms can never be hit.
  assign w_op  = 4'(IR);
  assign state = r_state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_START;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = S_START;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    Outload = 1'b0;
    Halt    = 1'b0;
    Err     = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        IRload = MemReady;
        PCload = MemReady;
        w_next = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        Meminst = 1'b1;
        case (w_op)
          4'd0:    w_next = S_LOAD;
          4'd1:    w_next = S_STORE;
          4'd2:    w_next = S_ADD;
          4'd3:    w_next = S_SUB;
          4'd4:    w_next = S_INPUT;
          4'd5:    w_next = S_JZ;
          4'd6:    w_next = S_JPOS;
          4'd7:    w_next = S_HALT;
          4'd8:    w_next = S_OUT;
          4'd9:    w_next = S_JNZ;
          4'd10:   w_next = S_JMP;
          4'd11:   w_next = S_NOP;
          default: w_next = S_TRAP;
        endcase
      end
      S_LOAD, S_ADD, S_SUB: begin
        Meminst = 1'b1;
        Asel    = (r_state == S_LOAD) ? 2'b10 : 2'b00;
        Sub     = (r_state == S_SUB);
        Aload   = MemReady;
        w_next  = MemReady ? S_START : r_state;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
        w_next  = MemReady ? S_START : S_STORE;
      end
      // Leaving on the first Enter edge keeps A written exactly once.
      S_INPUT: begin
        Asel   = 2'b01;
        Aload  = Enter;
        w_next = Enter ? S_START : S_INPUT;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_JNZ: begin
        JMPmux = 1'b1;
        PCload = ~Aeq0;
      end
      S_JMP: begin
        JMPmux = 1'b1;
        PCload = 1'b1;
      end
      S_OUT: Outload = 1'b1;
      S_NOP: w_next = S_START;
      S_HALT: begin
        Halt   = 1'b1;
        w_next = (HALT_RESUME && Enter) ? S_START : S_HALT;
      end
      S_TRAP: begin
        Halt   = 1'b1;
        Err    = (OPW == 4);
        w_next = S_TRAP;
      end
      default: w_next = S_START;
    endcase
  end

endmodule
